adc_seq_ctrl: RTL and testbench

Sequencer for the 12-bit handshake ADC (start / EOC / OE / data). It generates sample triggers, either periodic or software-requested, and runs the full start-convert-read handshake with per-phase timeouts. It delivers one 12-bit sample per trigger as a single-cycle valid pulse to the PID datapath.

---
 rtl/adc_seq_pkg.sv | 29 ++
 rtl/adc_seq_ctrl_if.sv | 31 +++
 rtl/adc_trig_timer.sv | 39 +++
 rtl/adc_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_seq_pkg.sv
// +----------------------------------------------------------------------+
// | adc_seq_pkg : shared types and constants for the ADC sequencer        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package adc_seq_pkg;

  localparam int ADC_DW      = 12;
  localparam int TIMEOUT_DEF = 64;
  localparam int WAIT_CW     = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_READ      = 3'd4,
    ST_RELEASE   = 3'd5,
    ST_ERR       = 3'd6
  } adc_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_seq_ctrl_if.sv
// +----------------------------------------------------------------------+
// | adc_seq_ctrl_if : start/EOC/OE/data handshake to the external ADC     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface adc_seq_ctrl_if;
  import adc_seq_pkg::*;

  logic              adc_start;
  logic              adc_oe;
  logic              adc_eoc;
  logic [ADC_DW-1:0] adc_data_in;

  modport master (
    output adc_start,
    output adc_oe,
    input  adc_eoc,
    input  adc_data_in
  );

  modport slave (
    input  adc_start,
    input  adc_oe,
    output adc_eoc,
    output adc_data_in
  );

endinterface

`default_nettype wire

// File: rtl/adc_trig_timer.sv
// +----------------------------------------------------------------------+
// | adc_trig_timer : periodic sample trigger OR'd with software trigger   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module adc_trig_timer #(
  parameter int PERIOD_W = 16
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                i_enable,
  input  wire logic [PERIOD_W-1:0] i_period,
  input  wire logic                i_sw_trig,
  output logic                     o_trig
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                w_run;
  logic                w_wrap;

  assign w_run  = i_enable && (i_period != '0);
  // >= so a period shortened mid-count wraps at once instead of rolling over
  assign w_wrap = w_run && (r_cnt >= (i_period - PERIOD_W'(1)));
  assign o_trig = i_sw_trig | w_wrap;

  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PERIOD_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | adc_seq_ctrl : ADC trigger + start/convert/read handshake sequencer   |
// | Optional ADC_OVERSAMPLE_EN averages 2^OVERSAMPLE_LOG2 conversions.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int START_CYCLES    = 2,
  parameter int OE_CYCLES       = 2,
  parameter int TIMEOUT         = 64,
  parameter int PERIOD_W        = 16,
  parameter int OVERSAMPLE_LOG2 = 2
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                enable,
  input  wire logic [PERIOD_W-1:0] sample_period,
  input  wire logic                sw_trig,
  input  wire logic                err_clr,
  adc_seq_ctrl_if.master           adc,
  output logic [ADC_DW-1:0]        sample_data,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     timeout_err,
  output logic                     overrun
);

  localparam logic [2:0] S_IDLE      = ST_IDLE;
  localparam logic [2:0] S_START     = ST_START;
  localparam logic [2:0] S_WAIT_LOW  = ST_WAIT_LOW;
  localparam logic [2:0] S_WAIT_HIGH = ST_WAIT_HIGH;
  localparam logic [2:0] S_READ      = ST_READ;
  localparam logic [2:0] S_RELEASE   = ST_RELEASE;
  localparam logic [2:0] S_ERR       = ST_ERR;

  localparam int c_CNT_MAX = (TIMEOUT > START_CYCLES)
                           ? ((TIMEOUT > OE_CYCLES) ? TIMEOUT : OE_CYCLES)
                           : ((START_CYCLES > OE_CYCLES) ? START_CYCLES : OE_CYCLES);
  localparam int c_CNT_W   = cnt_width(c_CNT_MAX);

  localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_OE_LAST    = c_CNT_W'(OE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST   = c_CNT_W'(TIMEOUT - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_pending;
  logic               r_adc_start;
  logic               r_adc_oe;
  logic [ADC_DW-1:0]  r_sample_data;
  logic               r_sample_valid;
  logic               r_timeout_err;
  logic               r_overrun;
  logic               w_trig;
  logic               w_launch;
  logic               w_oe_last;

`ifdef ADC_OVERSAMPLE_EN
  localparam int c_ACC_W = ADC_DW + OVERSAMPLE_LOG2;
  logic [c_ACC_W-1:0]         r_acc;
  logic [OVERSAMPLE_LOG2-1:0] r_conv;
  logic                       w_last_conv;
  assign w_last_conv = &r_conv;
`else
  localparam int c_os_log2_unused = OVERSAMPLE_LOG2;
  logic [ADC_DW-1:0] r_capt;
`endif

  adc_trig_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_trig_timer (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (enable),
    .i_period  (sample_period),
    .i_sw_trig (sw_trig),
    .o_trig    (w_trig)
  );

  assign w_launch  = (r_state == S_IDLE) && r_pending;
  assign w_oe_last = (r_cnt == c_OE_LAST);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:      if (r_pending) w_nxt = S_START;
      S_START:     if (r_cnt == c_START_LAST) w_nxt = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!adc.adc_eoc)              w_nxt = S_WAIT_HIGH;
        else if (r_cnt == c_TMO_LAST)  w_nxt = S_ERR;
      end
      S_WAIT_HIGH: begin
        if (adc.adc_eoc)               w_nxt = S_READ;
        else if (r_cnt == c_TMO_LAST)  w_nxt = S_ERR;
      end
      S_READ:      if (w_oe_last) w_nxt = S_RELEASE;
`ifdef ADC_OVERSAMPLE_EN
      S_RELEASE:   w_nxt = w_last_conv ? S_IDLE : S_START;
`else
      S_RELEASE:   w_nxt = S_IDLE;
`endif
      S_ERR:       w_nxt = S_IDLE;
      default:     w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_pending      <= 1'b0;
      r_adc_start    <= 1'b0;
      r_adc_oe       <= 1'b0;
      r_sample_data  <= '0;
      r_sample_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_overrun      <= 1'b0;
`ifdef ADC_OVERSAMPLE_EN
      r_acc          <= '0;
      r_conv         <= '0;
`else
      r_capt         <= '0;
`endif
    end else begin
      r_state     <= w_nxt;
      // single shared counter: phase length in START/READ, timeout in the waits
      r_cnt       <= (w_nxt != r_state) ? '0 : r_cnt + c_CNT_W'(1);
      r_adc_start <= (w_nxt == S_START);
      r_adc_oe    <= (w_nxt == S_READ);

      if (w_trig)        r_pending <= 1'b1;
      else if (w_launch) r_pending <= 1'b0;

      if (w_trig && r_pending) r_overrun <= 1'b1;
      else if (err_clr)        r_overrun <= 1'b0;

      if (w_nxt == S_ERR)      r_timeout_err <= 1'b1;
      else if (err_clr)        r_timeout_err <= 1'b0;

      r_sample_valid <= 1'b0;
`ifdef ADC_OVERSAMPLE_EN
      if (w_launch) begin
        r_acc  <= '0;
        r_conv <= '0;
      end
      if ((r_state == S_READ) && w_oe_last) begin
        r_acc <= r_acc + c_ACC_W'(adc.adc_data_in);
      end
      if (r_state == S_RELEASE) begin
        if (w_last_conv) begin
          r_sample_valid <= 1'b1;
          r_sample_data  <= r_acc[c_ACC_W-1:OVERSAMPLE_LOG2];
        end else begin
          r_conv <= r_conv + 1'b1;
        end
      end
`else
      if ((r_state == S_READ) && w_oe_last) begin
        r_capt <= adc.adc_data_in;
      end
      if (r_state == S_RELEASE) begin
        r_sample_valid <= 1'b1;
        r_sample_data  <= r_capt;
      end
`endif
    end
  end

  assign adc.adc_start = r_adc_start;
  assign adc.adc_oe    = r_adc_oe;
  assign sample_data   = r_sample_data;
  assign sample_valid  = r_sample_valid;
  assign busy          = (r_state != S_IDLE);
  assign timeout_err   = r_timeout_err;
  assign overrun       = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_adc_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_adc_seq_ctrl : directed self-checking bench for adc_seq_ctrl       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_adc_seq_ctrl;
  import adc_seq_pkg::*;

`ifdef ADC_OVERSAMPLE_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif
  localparam int CONV_TIME = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [15:0]       sample_period;
  logic              sw_trig;
  logic              err_clr;
  logic [ADC_DW-1:0] sample_data;
  logic              sample_valid;
  logic              busy;
  logic              timeout_err;
  logic              overrun;

  logic              stuck;
  logic              os_mode;
  logic [ADC_DW-1:0] tb_data;
  logic [ADC_DW-1:0] os_cur;
  logic [ADC_DW-1:0] os_vals [4];
  int                os_idx;
  int                conv_cnt;
  logic              prev_start;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cnt_start = 0;
  int cnt_oe = 0;
  int cnt_valid = 0;
  int cnt_both = 0;

  adc_seq_ctrl_if adc_if ();

  adc_seq_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .sample_period (sample_period),
    .sw_trig       (sw_trig),
    .err_clr       (err_clr),
    .adc           (adc_if),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign adc_if.adc_data_in = os_mode ? os_cur : tb_data;

  // ADC model: EOC drops while start is high, rises CONV_TIME clocks after start ends
  always @(negedge clk) begin
    if (!os_mode) os_idx = 0;
    if (stuck) begin
      adc_if.adc_eoc = 1'b1;
      conv_cnt = 0;
    end else if (adc_if.adc_start) begin
      if (!prev_start && os_mode) begin
        os_cur = os_vals[os_idx];
        os_idx = (os_idx + 1) % 4;
      end
      adc_if.adc_eoc = 1'b0;
      conv_cnt = CONV_TIME;
    end else if (conv_cnt > 1) begin
      conv_cnt = conv_cnt - 1;
    end else if (conv_cnt == 1) begin
      conv_cnt = 0;
      adc_if.adc_eoc = 1'b1;
    end
    prev_start = adc_if.adc_start;
  end

  always @(negedge clk) begin
    if (adc_if.adc_start) cnt_start <= cnt_start + 1;
    if (adc_if.adc_oe)    cnt_oe    <= cnt_oe + 1;
    if (sample_valid)     cnt_valid <= cnt_valid + 1;
    if (adc_if.adc_start && adc_if.adc_oe) cnt_both <= cnt_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int t);
    t = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_sw_trig();
    sw_trig = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0;
  endtask

  initial begin
    int t, tprev, s_start, s_oe, s_valid;
    logic [ADC_DW-1:0] vals [2];

    os_vals[0] = 12'd100; os_vals[1] = 12'd101;
    os_vals[2] = 12'd102; os_vals[3] = 12'd104;
    vals[0] = 12'hFFF; vals[1] = 12'h001;
    os_cur = '0; os_idx = 0; conv_cnt = 0; prev_start = 1'b0;
    adc_if.adc_eoc = 1'b1;
    rst = 1'b1; enable = 1'b0; sample_period = '0; sw_trig = 1'b0;
    err_clr = 1'b0; stuck = 1'b0; os_mode = 1'b0; tb_data = '0;

    repeat (3) @(negedge clk);
    check("rst_start", {31'd0, adc_if.adc_start}, 32'd0);
    check("rst_oe",    {31'd0, adc_if.adc_oe},    32'd0);
    check("rst_busy",  {31'd0, busy},             32'd0);
    check("rst_valid", {31'd0, sample_valid},     32'd0);
    check("rst_flags", {30'd0, timeout_err, overrun}, 32'd0);
    check("rst_data",  {20'd0, sample_data},      32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single software trigger
    tb_data = 12'hA5C;
    s_start = cnt_start; s_oe = cnt_oe; s_valid = cnt_valid;
    sw_trig = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0;
    check("lat_t1_start", {31'd0, adc_if.adc_start}, 32'd0);
    @(negedge clk);
    check("lat_t2_start", {31'd0, adc_if.adc_start}, 32'd1);
    wait_valid(40 * NCONV, t);
    check("sw_valid_seen", {31'd0, sample_valid}, 32'd1);
    check("sw_data", {20'd0, sample_data}, 32'hA5C);
    check("sw_busy_done", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("sw_start_cycles", cnt_start - s_start, 2 * NCONV);
    check("sw_oe_cycles", cnt_oe - s_oe, 2 * NCONV);
    check("sw_valid_count", cnt_valid - s_valid, 32'd1);

    // boundary data values
    foreach (vals[k]) begin
      tb_data = vals[k];
      pulse_sw_trig();
      wait_valid(40 * NCONV, t);
      check("edge_data", {20'd0, sample_data}, {20'd0, vals[k]});
      repeat (3) @(negedge clk);
    end

    // periodic triggering, period 100
    enable = 1'b1; sample_period = 16'd100; tb_data = 12'h3C3;
    tprev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_valid(150, t);
      check("per_valid_seen", {31'd0, sample_valid}, 32'd1);
      if (k > 0) check("per_gap", t - tprev, 32'd100);
      tprev = t;
    end
    check("per_overrun", {31'd0, overrun}, 32'd0);
    check("per_data", {20'd0, sample_data}, 32'h3C3);
    enable = 1'b0;
    repeat (100) @(negedge clk);

    // period shorter than a conversion
    s_valid = cnt_valid;
    enable = 1'b1; sample_period = 16'd8;
    repeat (100 * NCONV) @(negedge clk);
    check("fast_overrun", {31'd0, overrun}, 32'd1);
    enable = 1'b0;
    repeat (60 * NCONV) @(negedge clk);
    check("fast_flowing", {31'd0, (cnt_valid - s_valid) >= 3}, 32'd1);
    check("fast_idle", {31'd0, busy}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("fast_clr", {31'd0, overrun}, 32'd0);
    check("no_onehot_viol", cnt_both, 32'd0);

    // EOC stuck high -> timeout in WAIT_LOW
    stuck = 1'b1;
    repeat (2) @(negedge clk);
    s_valid = cnt_valid;
    pulse_sw_trig();
    repeat (66) @(negedge clk);
    check("tmo_before", {31'd0, timeout_err}, 32'd0);
    check("tmo_busy_wait", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("tmo_set", {31'd0, timeout_err}, 32'd1);
    check("tmo_err_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("tmo_idle", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("tmo_sticky", {31'd0, timeout_err}, 32'd1);
    check("tmo_no_valid", cnt_valid - s_valid, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("tmo_clr", {31'd0, timeout_err}, 32'd0);
    stuck = 1'b0;
    repeat (5) @(negedge clk);

    // reset during READ
    s_valid = cnt_valid;
    pulse_sw_trig();
    for (int i = 0; i < 60; i++) begin
      if (adc_if.adc_oe) break;
      @(negedge clk);
    end
    check("rr_in_read", {31'd0, adc_if.adc_oe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rr_oe", {31'd0, adc_if.adc_oe}, 32'd0);
    check("rr_busy", {31'd0, busy}, 32'd0);
    check("rr_data", {20'd0, sample_data}, 32'd0);
    repeat (40) @(negedge clk);
    check("rr_no_valid", cnt_valid - s_valid, 32'd0);

`ifdef ADC_OVERSAMPLE_EN
    os_mode = 1'b1;
    @(negedge clk);
    s_valid = cnt_valid;
    pulse_sw_trig();
    wait_valid(200, t);
    check("os_valid_seen", {31'd0, sample_valid}, 32'd1);
    check("os_avg", {20'd0, sample_data}, 32'd101);
    repeat (10) @(negedge clk);
    check("os_one_valid", cnt_valid - s_valid, 32'd1);
    os_mode = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
